tpmem_pingpong_nxn: RTL and testbench

Parametrised double-buffered transpose memory for the 2-D DCT datapath, sitting between the 1-D row DCT and the 1-D column DCT. It accepts N-element row vectors into one of two banks while the other bank is drained, either column-wise or in row order. Per-bank full/empty state and valid/ready handshakes on both sides replace the external flag-driven bank selection used so far. It also allows stalls on either side without data loss.

---
 rtl/tpmem_pingpong_nxn.sv | 121 ++++++++++++
 tb/tb_tpmem_pingpong_nxn.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tpmem_pingpong_nxn.sv
// Double-buffered NxN transpose memory between the row DCT and the column DCT.
// Latency: the first vector of a block is valid the cycle after its last row is written.
// Backpressure: in_ready drops while both banks are full; out_vec holds while out_valid & ~out_ready.
module tpmem_pingpong_nxn #(
  parameter int N         = 16,
  parameter int W         = 11,
  parameter bit TRANSPOSE = 1'b1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N*W-1:0] in_vec,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*W-1:0] out_vec,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_first,
  output logic           out_last,
  output logic [1:0]     bank_full
);

  localparam int            CW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  logic [W-1:0]  mem [2][N][N];
  logic          wb;
  logic          rb;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;

  logic          wr_fire;
  logic          rd_fire;
  logic          wr_wrap;
  logic          rd_wrap;
  logic [1:0]    set_full;
  logic [1:0]    clr_full;

  // Both ready/valid are pure functions of registered state, so there is no
  // combinational path from in_valid to out_valid or from out_ready to in_ready.
  assign in_ready  = ~bank_full[wb];
  assign out_valid = bank_full[rb];
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;
  assign wr_wrap   = (wr_cnt == CNT_MAX);
  assign rd_wrap   = (rd_cnt == CNT_MAX);
  assign out_first = (rd_cnt == '0);
  assign out_last  = rd_wrap;

  // Writer and reader only ever touch different banks, so set and clear never collide.
  assign set_full = (wr_fire && wr_wrap) ? (wb ? 2'b10 : 2'b01) : 2'b00;
  assign clr_full = (rd_fire && rd_wrap) ? (rb ? 2'b10 : 2'b01) : 2'b00;

  // Write pointer: advance a row per accepted vector, swap banks after row N-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt <= '0;
      wb     <= 1'b0;
    end else if (wr_fire) begin
      if (wr_wrap) begin
        wr_cnt <= '0;
        wb     <= ~wb;
      end else begin
        wr_cnt <= wr_cnt + CW'(1);
      end
    end
  end

  // Read pointer: advance a vector per handshake, swap banks after vector N-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt <= '0;
      rb     <= 1'b0;
    end else if (rd_fire) begin
      if (rd_wrap) begin
        rd_cnt <= '0;
        rb     <= ~rb;
      end else begin
        rd_cnt <= rd_cnt + CW'(1);
      end
    end
  end

  // Bank occupancy: full once the last row lands, empty once the last vector leaves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full | set_full) & ~clr_full;
    end
  end

  // Storage: one row of the write bank per accepted input vector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            mem[b][r][c] <= '0;
          end
        end
      end
    end else if (wr_fire) begin
      for (int c = 0; c < N; c++) begin
        mem[wb][wr_cnt][c] <= in_vec[c*W +: W];
      end
    end
  end

  // Output select: column rd_cnt when transposing, otherwise row rd_cnt.
  always_comb begin
    out_vec = '0;
    for (int k = 0; k < N; k++) begin
      if (TRANSPOSE) begin
        out_vec[k*W +: W] = mem[rb][k][rd_cnt];
      end else begin
        out_vec[k*W +: W] = mem[rb][rd_cnt][k];
      end
    end
  end

endmodule

// File: tb/tb_tpmem_pingpong_nxn.sv
// Directed bench: N=4/W=8 transposing instance plus N=3/W=11 row-order instance.
// Inputs are driven 1 ns after the rising edge; outputs are checked at the same point.
// Expected vectors are hand-computed constants or built from a simple (r,c) value formula.
module tb_tpmem_pingpong_nxn;

  logic clk;
  logic rstn;

  // N=4, W=8, TRANSPOSE=1
  logic [31:0] in_vec0;
  logic        in_valid0;
  logic        in_ready0;
  logic [31:0] out_vec0;
  logic        out_valid0;
  logic        out_ready0;
  logic        out_first0;
  logic        out_last0;
  logic [1:0]  bank_full0;

  // N=3, W=11, TRANSPOSE=0
  logic [32:0] in_vec1;
  logic        in_valid1;
  logic        in_ready1;
  logic [32:0] out_vec1;
  logic        out_valid1;
  logic        out_ready1;
  logic        out_first1;
  logic        out_last1;
  logic [1:0]  bank_full1;

  int n_cmp;
  int n_bad;

  tpmem_pingpong_nxn #(.N(4), .W(8), .TRANSPOSE(1'b1)) u_tp (
    .clk(clk), .rstn(rstn),
    .in_vec(in_vec0), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_vec(out_vec0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_first(out_first0), .out_last(out_last0), .bank_full(bank_full0)
  );

  tpmem_pingpong_nxn #(.N(3), .W(11), .TRANSPOSE(1'b0)) u_row (
    .clk(clk), .rstn(rstn),
    .in_vec(in_vec1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_vec(out_vec1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_first(out_first1), .out_last(out_last1), .bank_full(bank_full1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse placed between edges.
  task automatic do_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  // Element (r,c) of block blk is blk*64 + 16r + c.
  function automatic logic [31:0] row_vec(input int blk, input int r);
    logic [31:0] v;
    for (int c = 0; c < 4; c++) v[c*8 +: 8] = 8'(blk*64 + 16*r + c);
    return v;
  endfunction

  function automatic logic [31:0] col_vec(input int blk, input int c);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(blk*64 + 16*k + c);
    return v;
  endfunction

  function automatic logic [32:0] pack3(input int e0, input int e1, input int e2);
    return {11'(e2), 11'(e1), 11'(e0)};
  endfunction

  logic [31:0] tcol [4];
  logic [32:0] rrow [6];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn = 1'b0;
    in_vec0 = '0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    in_vec1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    tcol[0] = 32'h30201000; tcol[1] = 32'h31211101;
    tcol[2] = 32'h32221202; tcol[3] = 32'h33231303;

    // ---- reset values ----
    #3;
    check("rst in_ready", 64'(in_ready0), 64'd1);
    check("rst out_valid", 64'(out_valid0), 64'd0);
    check("rst out_first", 64'(out_first0), 64'd1);
    check("rst out_last", 64'(out_last0), 64'd0);
    check("rst out_vec", 64'(out_vec0), 64'd0);
    check("rst bank_full", 64'(bank_full0), 64'd0);
    tick();
    rstn = 1'b1;

    // ---- basic transpose: (r,c)=16r+c ----
    out_ready0 = 1'b1;
    for (int r = 0; r < 4; r++) begin
      in_vec0 = row_vec(0, r);
      in_valid0 = 1'b1;
      check("basic out_valid early", 64'(out_valid0), 64'd0);
      tick();
    end
    in_valid0 = 1'b0;
    check("basic bank_full", 64'(bank_full0), 64'd1);
    check("basic in_ready", 64'(in_ready0), 64'd1);
    for (int c = 0; c < 4; c++) begin
      check("basic out_valid", 64'(out_valid0), 64'd1);
      check("basic out_vec", 64'(out_vec0), 64'(tcol[c]));
      check("basic out_first", 64'(out_first0), 64'(c == 0));
      check("basic out_last", 64'(out_last0), 64'(c == 3));
      tick();
    end
    check("basic drained valid", 64'(out_valid0), 64'd0);
    check("basic drained full", 64'(bank_full0), 64'd0);

    // ---- streaming 12 rows, continuous valid/ready ----
    do_reset();
    out_ready0 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 12) begin
        in_vec0 = row_vec(i / 4, i % 4);
        in_valid0 = 1'b1;
        check("stream in_ready", 64'(in_ready0), 64'd1);
      end else begin
        in_valid0 = 1'b0;
      end
      if (i >= 4 && i < 16) begin
        check("stream out_valid", 64'(out_valid0), 64'd1);
        check("stream out_vec", 64'(out_vec0), 64'(col_vec((i - 4) / 4, (i - 4) % 4)));
        check("stream bank_full", 64'(bank_full0), (((i - 4) / 4) % 2 == 0) ? 64'd1 : 64'd2);
      end else if (i >= 16) begin
        check("stream idle", 64'(out_valid0), 64'd0);
      end
      tick();
    end

    // ---- backpressure: 9 rows with out_ready=0 ----
    do_reset();
    out_ready0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_vec0 = row_vec(i / 4, i % 4);
      in_valid0 = 1'b1;
      check("bp in_ready", 64'(in_ready0), 64'd1);
      tick();
    end
    in_vec0 = row_vec(2, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp held in_ready", 64'(in_ready0), 64'd0);
      check("bp bank_full", 64'(bank_full0), 64'd3);
      check("bp out_vec stable", 64'(out_vec0), 64'(col_vec(0, 0)));
      check("bp out_first", 64'(out_first0), 64'd1);
      tick();
    end
    out_ready0 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("bp drain col", 64'(out_vec0), 64'(col_vec(0, c)));
      check("bp drain in_ready", 64'(in_ready0), 64'd0);
      tick();
    end
    // Bank 0 freed on the last read edge: writer sees it one cycle later.
    check("freeing in_ready", 64'(in_ready0), 64'd1);
    check("freeing bank_full", 64'(bank_full0), 64'd2);
    check("blk1 col0", 64'(out_vec0), 64'(col_vec(1, 0)));
    tick();
    in_valid0 = 1'b0;
    for (int c = 1; c < 4; c++) begin
      check("blk1 col", 64'(out_vec0), 64'(col_vec(1, c)));
      tick();
    end
    check("bp partial bank", 64'(bank_full0), 64'd0);
    check("bp partial in_ready", 64'(in_ready0), 64'd1);

    // ---- reset mid-block ----
    do_reset();
    out_ready0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_vec0 = 32'hAAAAAAAA;
      in_valid0 = 1'b1;
      tick();
    end
    in_valid0 = 1'b0;
    rstn = 1'b0;
    #1;
    check("midrst bank_full", 64'(bank_full0), 64'd0);
    check("midrst in_ready", 64'(in_ready0), 64'd1);
    check("midrst out_valid", 64'(out_valid0), 64'd0);
    check("midrst out_vec", 64'(out_vec0), 64'd0);
    tick();
    rstn = 1'b1;
    for (int r = 0; r < 4; r++) begin
      in_vec0 = row_vec(1, r);
      in_valid0 = 1'b1;
      tick();
    end
    in_valid0 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("midrst col", 64'(out_vec0), 64'(col_vec(1, c)));
      check("midrst first", 64'(out_first0), 64'(c == 0));
      tick();
    end
    check("midrst done", 64'(bank_full0), 64'd0);

    // ---- row-order instance, N=3, W=11 ----
    do_reset();
    rrow[0] = pack3(1, 2, 3);
    rrow[1] = pack3(4, 5, 6);
    rrow[2] = pack3(7, 8, 9);
    rrow[3] = pack3(2047, 0, 2047);
    rrow[4] = pack3(2047, 2047, 2047);
    rrow[5] = pack3(5, 2047, 6);
    out_ready1 = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i < 6) begin
        in_vec1 = rrow[i];
        in_valid1 = 1'b1;
        check("row in_ready", 64'(in_ready1), 64'd1);
      end else begin
        in_valid1 = 1'b0;
      end
      if (i >= 3 && i < 9) begin
        check("row out_valid", 64'(out_valid1), 64'd1);
        check("row out_vec", 64'(out_vec1), 64'(rrow[i - 3]));
        check("row out_last", 64'(out_last1), 64'((i - 3) % 3 == 2));
      end else if (i >= 9) begin
        check("row idle", 64'(out_valid1), 64'd0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
